// File: rtl/fetch_sequencer.sv
// Instruction fetch front end: owns the PC, reads one- or two-word instructions
// from a fixed-latency memory and hands each bundle downstream over valid/ready.
module fetch_sequencer #(
  parameter int                 WIDTH    = 16,
  parameter int                 MEM_LAT  = 1,
  parameter logic [WIDTH-1:0]   RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] imem_addr,
  output logic             imem_rd,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_instr,
  output logic [WIDTH-1:0] out_n,
  output logic [WIDTH-1:0] out_pc,
  output logic             out_long,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             halted,
  output logic [WIDTH-1:0] retired_count,
  output logic [2:0]       dbg_state
);

  // Handshake: a bundle transfers on any cycle where out_valid and out_ready
  // are both high; while out_valid is high and out_ready low the bundle holds.

  typedef enum logic [2:0] {
    S_FETCH1 = 3'd0,
    S_WAIT1  = 3'd1,
    S_FETCH2 = 3'd2,
    S_WAIT2  = 3'd3,
    S_VALID  = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] opc_pc_q, opc_pc_d;
  logic             long_q, long_d;
  logic [WIDTH-1:0] retired_q, retired_d;

  logic accept;
  logic accept_stp;

  function automatic logic is_long(input logic [WIDTH-1:0] word);
    logic [4:0] op;
    op = word[WIDTH-1 -: 5];
    return op[0] & (op[4:1] != 4'b0001) & (op[4:3] != 2'b11);
  endfunction

  function automatic logic is_stp(input logic [WIDTH-1:0] word);
    return word[WIDTH-1 -: 5] == 5'b11111;
  endfunction

  assign accept     = (state_q == S_VALID) && out_ready;
  assign accept_stp = accept && is_stp(instr_q);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    instr_d   = instr_q;
    n_d       = n_q;
    opc_pc_d  = opc_pc_q;
    long_d    = long_q;
    retired_d = retired_q;

    unique case (state_q)
      S_FETCH1: begin
        state_d = S_WAIT1;
        cnt_d   = 3'd1;
      end
      S_WAIT1: begin
        if (cnt_q == LAT) begin
          instr_d  = imem_rdata;
          opc_pc_d = pc_q;
          n_d      = '0;
          long_d   = 1'b0;
          state_d  = is_long(imem_rdata) ? S_FETCH2 : S_VALID;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_FETCH2: begin
        state_d = S_WAIT2;
        cnt_d   = 3'd1;
      end
      S_WAIT2: begin
        if (cnt_q == LAT) begin
          n_d     = imem_rdata;
          long_d  = 1'b1;
          state_d = S_VALID;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_VALID: begin
        if (out_ready) begin
          retired_d = retired_q + WIDTH'(1);
          pc_d      = pc_q + (long_q ? WIDTH'(2) : WIDTH'(1));
          state_d   = is_stp(instr_q) ? S_HALT : S_FETCH1;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH1;
      end
    endcase

    // Redirect overrides the PC step and restarts fetch, except that a
    // simultaneously retiring STP still halts.
    if (redirect && (state_q != S_HALT)) begin
      pc_d  = redirect_pc;
      cnt_d = 3'd0;
      if (!accept_stp) begin
        state_d = S_FETCH1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH1;
      pc_q      <= RESET_PC;
      cnt_q     <= 3'd0;
      instr_q   <= '0;
      n_q       <= '0;
      opc_pc_q  <= '0;
      long_q    <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
      n_q       <= n_d;
      opc_pc_q  <= opc_pc_d;
      long_q    <= long_d;
      retired_q <= retired_d;
    end
  end

  // A request issued alongside a redirect would be abandoned immediately, so it
  // is suppressed; this also keeps read strobes from landing on adjacent cycles.
  assign imem_rd       = ((state_q == S_FETCH1) || (state_q == S_FETCH2)) && !redirect && !reset;
  assign imem_addr     = reset ? RESET_PC : ((state_q == S_FETCH2) ? pc_q + WIDTH'(1) : pc_q);
  assign out_valid     = (state_q == S_VALID) && !reset;
  assign out_instr     = reset ? '0 : instr_q;
  assign out_n         = reset ? '0 : n_q;
  assign out_pc        = reset ? '0 : opc_pc_q;
  assign out_long      = reset ? 1'b0 : long_q;
  assign halted        = (state_q == S_HALT) && !reset;
  assign retired_count = reset ? '0 : retired_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Multi-cycle instruction fetch front end for the CPU, sitting between the instruction memory read port and the instruction decoder/execute stage. It owns the PC and fetches one- or two-word instructions (opcode word plus immediate N) from a memory with parametrised fixed read latency. It presents each complete instruction over a valid/ready handshake, accepts redirects (jump/call/return/skip targets computed downstream), halts on STP, and counts retired instructions.

Parameters:
WIDTH, 16, word/address width; the opcode is instr[WIDTH-1:WIDTH-5] and the long-form bit is instr[WIDTH-5].
MEM_LAT, 1, instruction memory read latency in cycles; legal range 1..4.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous active-high reset.
imem_addr  out  WIDTH  instruction memory read address.
imem_rd  out  1  read strobe, one cycle per request.
imem_rdata  in  WIDTH  read data, valid exactly MEM_LAT cycles after the imem_rd cycle.
out_valid  out  1  instruction bundle valid.
out_ready  in  1  downstream accepts the bundle when out_valid=1.
out_instr  out  WIDTH  opcode word.
out_n  out  WIDTH  immediate word; 0 for short instructions.
out_pc  out  WIDTH  address of the opcode word.
out_long  out  1  1 = two-word instruction.
redirect  in  1  load a new PC and flush.
redirect_pc  in  WIDTH  target PC.
halted  out  1  STP retired; fetch stopped.
retired_count  out  WIDTH  accepted-instruction counter, wraps modulo 2^WIDTH.

Behaviour:
- Reset (synchronous, priority over everything): state=FETCH1, pc=RESET_PC, latency counter=0. Outputs while reset is high: imem_rd=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_n=0, out_pc=0, out_long=0, halted=0, retired_count=0. Asserting reset mid-fetch discards all in-flight data.
- Long rule: long = op[0] & (op[4:1] != 4'b0001) & (op[4:3] != 2'b11), where op = opcode.
- FETCH1: imem_rd=1, imem_addr=pc. Next state is WAIT1 with counter=1.
- WAIT1: imem_rd=0. When counter==MEM_LAT, capture imem_rdata into out_instr and out_pc=pc. If the word is long, go to FETCH2; otherwise set out_n=0 and go to VALID. Otherwise increment the counter.
- FETCH2: imem_rd=1, imem_addr=pc+1 (wraps modulo 2^WIDTH). Next state is WAIT2.
- WAIT2: same counting as WAIT1. On counter==MEM_LAT, capture out_n, set out_long=1, and go to VALID.
- VALID: out_valid=1. The bundle is held stable until out_ready=1.
  - On acceptance: retired_count+=1. pc += 1 (short) or 2 (long), wrapping.
  - If the accepted opcode is 11111 (STP), go to HALT. Otherwise go to FETCH1.
- HALT: imem_rd=0, out_valid=0, halted=1 from the cycle after acceptance. Only reset leaves HALT; redirect is ignored.
- Timing for a short instruction from FETCH1 in cycle t: rdata in cycle t+MEM_LAT, out_valid=1 in cycle t+MEM_LAT+1. A long instruction adds MEM_LAT+1 cycles.
- Redirect: redirect=1 in any non-HALT cycle sets pc=redirect_pc and next state=FETCH1; out_valid is 0 the next cycle.
  - Any in-flight request is abandoned. Its late data is ignored because the counter restarts.
  - If redirect and an out_valid&out_ready acceptance happen in the same cycle:
    - the acceptance counts in retired_count;
    - redirect_pc wins over pc increment;
    - if the accepted instruction is STP, HALT wins over redirect.
- Back-to-back redirects: the latest one wins.
- retired_count wraps from all-ones to 0. imem_rd is never asserted in two consecutive cycles; only one request is outstanding.

Test Plan:
- MEM_LAT=1, memory[0]=0x0000 (NOP), out_ready=1: reset released at cycle 0 → imem_rd@0 addr 0; out_valid@2 with out_instr=0x0000, out_long=0, out_pc=0; next imem_addr=1 @3.
- MEM_LAT=3, memory[4]=0x7800 (MOV I), memory[5]=0xABCD, pc=4 → two reads (addr 4, 5); out_valid 8 cycles after the first read with out_n=0xABCD, out_long=1; pc=6 after accept.
- out_ready held 0 for 5 cycles with out_valid=1 → bundle stable and retired_count unchanged; ready=1 → retired_count+1 and fetch from the next pc.
- Redirect to 0x0100 during WAIT2 of a long instr (MEM_LAT=2) → stale rdata ignored; next imem_addr=0x0100; no out_valid for the aborted instr.
- Same-cycle accept of 0x2000 (JMP R) with redirect=1, redirect_pc=0x0040 → retired_count+1; next fetch address 0x0040.
- STP (0xF800) accepted → halted=1 next cycle, imem_rd stays 0, redirect ignored; reset → halted=0 and fetch restarts at RESET_PC. Also cover a long instruction at 0xFFFF, which fetches N from 0x0000.
